// File: rtl/ks_control_fsm.sv
// K&S multi-cycle control unit: fetch/decode/execute sequencing,
// RAM latency waits, single-step hold and cycle-limit watchdog.
package k_and_s_pkg;
  typedef enum logic [3:0] {
    I_NOP, I_LOAD, I_STORE, I_MOVE,
    I_ADD, I_SUB, I_AND, I_OR,
    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG,
    I_BNNEG, I_BOV, I_BNOV, I_HALT
  } decoded_instruction_type;
endpackage

module ks_control_fsm
  import k_and_s_pkg::*;
#(
  parameter int MEM_LATENCY = 0,
  parameter int CNT_W       = 16,
  parameter int MAX_CYCLES  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  input  logic                    step_en,
  input  logic                    step_req,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    write_reg_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    timeout,
  output logic                    instr_done
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_STEP, S_HALTED
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LATENCY);
  localparam logic [CNT_W-1:0] WD_LIM =
    CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);
  localparam bit WD_ON = (MAX_CYCLES > 0);

  state_t            state_q, state_d;
  logic [3:0]        wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout_q;
  logic              retire;
  logic              wd_fire;

  // unsigned_overflow is part of the flag bundle but no opcode tests it
  logic              unused_uov;
  assign unused_uov = unsigned_overflow;

  assign wd_fire = WD_ON && (state_q != S_HALTED)
                   && (cnt_q == WD_LIM);

  always_comb begin
    state_d          = state_q;
    wait_d           = wait_q;
    retire           = 1'b0;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    write_reg_enable = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = 2'b00;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    instr_done       = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        addr_sel = 1'b1;
        if (wait_q == LAT) begin
          ir_enable = 1'b1;
          wait_d    = 4'd0;
          state_d   = S_DECODE;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (decoded_instruction)
          I_ADD, I_SUB, I_AND, I_OR: begin
            case (decoded_instruction)
              I_SUB:   operation = 2'b01;
              I_AND:   operation = 2'b10;
              I_OR:    operation = 2'b11;
              default: operation = 2'b00;
            endcase
            write_reg_enable = 1'b1;
            flags_reg_enable = 1'b1;
            retire           = 1'b1;
          end
          I_MOVE: begin
            operation        = 2'b11;
            write_reg_enable = 1'b1;
            retire           = 1'b1;
          end
          I_STORE: begin
            ram_write_enable = 1'b1;
            retire           = 1'b1;
          end
          I_LOAD: begin
            wait_d  = 4'd0;
            state_d = S_MEM;
          end
          I_HALT:   state_d = S_HALTED;
          I_BRANCH: begin branch = 1'b1; retire = 1'b1; end
          I_BZERO:  begin branch = zero_op; retire = 1'b1; end
          I_BNZERO: begin branch = !zero_op; retire = 1'b1; end
          I_BNEG:   begin branch = neg_op; retire = 1'b1; end
          I_BNNEG:  begin branch = !neg_op; retire = 1'b1; end
          I_BOV:    begin branch = signed_overflow; retire = 1'b1; end
          I_BNOV:   begin branch = !signed_overflow; retire = 1'b1; end
          default:  retire = 1'b1;
        endcase
      end
      S_MEM: begin
        if (wait_q == LAT) begin
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          retire           = 1'b1;
          wait_d           = 4'd0;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_STEP: begin
        if (step_req || !step_en) state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
    if (retire) begin
      pc_enable  = 1'b1;
      instr_done = 1'b1;
      state_d    = step_en ? S_STEP : S_FETCH;
    end
    if (wd_fire) state_d = S_HALTED;
    // nothing may strobe the datapath while reset is held
    if (rst) begin
      branch           = 1'b0;
      pc_enable        = 1'b0;
      ir_enable        = 1'b0;
      write_reg_enable = 1'b0;
      addr_sel         = 1'b0;
      c_sel            = 1'b0;
      operation        = 2'b00;
      flags_reg_enable = 1'b0;
      ram_write_enable = 1'b0;
      instr_done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      wait_q    <= 4'd0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_q | wd_fire;
      if (state_q != S_HALTED && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
    end
  end

  assign halt    = (state_q == S_HALTED) && !rst;
  assign timeout = timeout_q && !rst;

endmodule

// File: doc/ks_control_fsm.md
Name: ks_control_fsm

Overview:
Parametrised multi-cycle control unit for the K&S datapath. It sequences fetch, decode and execute for every decoded_instruction_type opcode. It also supports configurable RAM read latency, a single-step debug mode and a cycle-limit watchdog that forces halt. It sits between the instruction decoder/flag register and the datapath/RAM enables, in the same position as control_unit.

Parameters:
MEM_LATENCY, 0, extra wait cycles for a RAM read (0..15); applies to fetch and LOAD
CNT_W, 16, width of watchdog cycle counter
MAX_CYCLES, 0, watchdog limit in cycles after reset; 0 disables watchdog

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
decoded_instruction  input  decoded_instruction_type  current IR decode (k_and_s_pkg)
zero_op  input  1  registered zero flag
neg_op  input  1  registered negative flag
unsigned_overflow  input  1  registered unsigned overflow flag
signed_overflow  input  1  registered signed overflow flag
step_en  input  1  single-step mode enable
step_req  input  1  one-cycle pulse: release one instruction in step mode
branch  output  1  PC loads branch target instead of PC+1
pc_enable  output  1  PC update strobe
ir_enable  output  1  IR load strobe
write_reg_enable  output  1  register file write
addr_sel  output  1  1=PC drives RAM address, 0=instruction address field
c_sel  output  1  0=ALU result to reg file, 1=RAM data
operation  output  2  ALU op: 00 add, 01 sub, 10 and, 11 or
flags_reg_enable  output  1  flag register load
ram_write_enable  output  1  RAM write strobe
halt  output  1  sticky halted indication
timeout  output  1  sticky; halt caused by watchdog
instr_done  output  1  one-cycle pulse on each retired instruction

Behaviour:
- One clock domain. Reset is synchronous, active-high, and clk and rst are the only clock and reset.
- While rst=1, all outputs are 0. State goes to FETCH. Wait counter and watchdog counter clear.
- States: FETCH, DECODE, EXEC, MEM_WAIT, STEP_WAIT, HALTED.
- Outputs not listed for a state are 0.
- FETCH:
  - addr_sel=1.
  - The internal wait count runs 0..MEM_LATENCY.
  - At count==MEM_LATENCY: ir_enable=1, next state DECODE.
  - Fetch therefore takes MEM_LATENCY+1 cycles.
- DECODE: 1 cycle, next state EXEC.
- EXEC for ADD/SUB/AND/OR:
  - operation = 00/01/10/11.
  - c_sel=0, write_reg_enable=1, flags_reg_enable=1, pc_enable=1.
  - The instruction retires.
- EXEC for MOVE: operation=11, c_sel=0, write_reg_enable=1, flags_reg_enable=0, pc_enable=1. Retires.
- EXEC for STORE: addr_sel=0, ram_write_enable=1 for exactly this one cycle, pc_enable=1. Retires.
- EXEC for LOAD: addr_sel=0, next state MEM_WAIT.
- MEM_WAIT:
  - addr_sel=0, with a wait count 0..MEM_LATENCY.
  - At the final count: c_sel=1, write_reg_enable=1, pc_enable=1. Retires.
  - With MEM_LATENCY=0, MEM_WAIT lasts one cycle.
- EXEC for BRANCH/BZERO/BNZERO/BNEG/BNNEG/BOV/BNOV:
  - Conditions: 1 / zero_op / !zero_op / neg_op / !neg_op / signed_overflow / !signed_overflow.
  - Taken: branch=1, pc_enable=1.
  - Not taken: branch=0, pc_enable=1.
  - Retires either way.
- EXEC for NOP: pc_enable=1. Retires.
- EXEC for HALT: next state HALTED, no retire pulse, pc_enable=0.
- Retire cycle:
  - instr_done=1 in the same cycle as the retiring pc_enable.
  - Next state is STEP_WAIT if step_en=1, else FETCH.
- STEP_WAIT:
  - All strobes 0.
  - step_req=1 moves to FETCH next cycle.
  - step_req is ignored in every other state.
  - Clearing step_en while in STEP_WAIT moves to FETCH next cycle.
- HALTED:
  - halt=1; all other strobes 0.
  - Left only by rst. halt stays 1 through the HALTED state.
- Watchdog (MAX_CYCLES>0):
  - The counter increments every non-reset cycle and saturates at 2^CNT_W-1.
  - When the counter reaches MAX_CYCLES-1 in a non-HALTED state, next state is HALTED and timeout is set.
  - Watchdog takes priority over any retire in that cycle: strobes still assert in the cycle, the transition is to HALTED, and instr_done still pulses.
  - The counter freezes in HALTED. timeout stays 0 on a HALT-instruction stop.
- halt and timeout are registered (asserted from the first HALTED cycle); all strobes are combinational from state plus decode.
- Undefined or unlisted opcodes behave as NOP.
- Reset mid-LOAD or mid-fetch: no write_reg_enable or pc_enable is issued on or after the reset cycle.

Test Plan:
- MEM_LATENCY=0, program ADD;HALT → ir_enable at cycle 0 after reset release; EXEC at cycle 2 with write_reg_enable=flags_reg_enable=pc_enable=instr_done=1 and operation=00; halt=1 from cycle 6, timeout=0.
- MEM_LATENCY=2, LOAD → fetch takes 3 cycles, MEM_WAIT takes 3 cycles; c_sel=1 and write_reg_enable=1 only in the 3rd MEM_WAIT cycle; addr_sel=0 throughout EXEC and MEM_WAIT; total instruction length 8 cycles.
- BZERO with zero_op=1 → branch=1, pc_enable=1; with zero_op=0 → branch=0, pc_enable=1; BOV with signed_overflow=1 → branch=1.
- STORE → ram_write_enable high for exactly 1 cycle, coincident with pc_enable; write_reg_enable=0.
- step_en=1, stream of NOPs → after each instr_done, FSM idles in STEP_WAIT with all strobes 0 for 10 cycles; step_req pulse → next ir_enable exactly 1 cycle later (MEM_LATENCY=0).
- MAX_CYCLES=20, endless NOP loop → halt=1 and timeout=1 from cycle 20 after reset release; rst=1 for 1 cycle → halt=timeout=0 and fetch restarts.
